// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 1 (CPOL=0, CPHA=1), MSB-first, with a divided serial clock.
// One byte is exchanged per start strobe; rx_byte holds the last completed byte.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       spi_clk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cntWrap;
    logic [2:0]       idx_q;
    logic             lastBit_q;
    logic [7:0]       txShift_q;
    logic [7:0]       rxShift_q;
    logic [7:0]       rxByte_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             csN_q;
    logic             busy_q;
    logic             done_q;

    always_comb begin
        cntWrap = (cnt_q == CNT_MAX);
        cnt_d   = cntWrap ? '0 : cnt_q + 1'b1;
    end

    // DONE is the extra cycle after the last LOW phase; the completion
    // outputs land on the edge leaving it, so the done=1 cycle is already IDLE
    // and a new start can be accepted there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd7;
            lastBit_q <= 1'b0;
            txShift_q <= 8'h00;
            rxShift_q <= 8'h00;
            rxByte_q  <= 8'h00;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            csN_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= SETUP;
                        cnt_q     <= '0;
                        txShift_q <= tx_byte;
                        idx_q     <= 3'd7;
                        lastBit_q <= 1'b0;
                        csN_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SETUP: begin
                    cnt_q <= cnt_d;
                    if (cntWrap) begin
                        state_q <= HIGH;
                        sclk_q  <= 1'b1;
                        mosi_q  <= txShift_q[idx_q];
                    end
                end
                HIGH: begin
                    cnt_q <= cnt_d;
                    if (cntWrap) begin
                        state_q          <= LOW;
                        sclk_q           <= 1'b0;
                        rxShift_q[idx_q] <= miso;
                        idx_q            <= idx_q - 3'd1;
                        lastBit_q        <= (idx_q == 3'd0);
                    end
                end
                LOW: begin
                    cnt_q <= cnt_d;
                    if (cntWrap) begin
                        if (lastBit_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= HIGH;
                            sclk_q  <= 1'b1;
                            mosi_q  <= txShift_q[idx_q];
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    csN_q    <= 1'b1;
                    mosi_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    rxByte_q <= rxShift_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_byte = rxByte_q;
    assign spi_clk = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = csN_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=4 and CLK_DIV=1 instances, loopback and a mode-1 responder,
// checked against expected bytes, edge counts and start-to-done latency.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    logic       start4 = 1'b0, start1 = 1'b0;
    logic [7:0] tx4 = 8'h00, tx1 = 8'h00;
    logic       busy4, done4, sclk4, mosi4, cs4, miso4;
    logic       busy1, done1, sclk1, mosi1, cs1, miso1;
    logic [7:0] rx4, rx1;

    logic       loop4 = 1'b1;
    logic       respMiso = 1'b0;
    logic [7:0] respTx = 8'h00, respSh = 8'h00, respRx = 8'h00;

    assign miso4 = loop4 ? mosi4 : respMiso;
    assign miso1 = mosi1;

    spi_master #(.CLK_DIV(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .tx_byte(tx4), .busy(busy4), .done(done4),
        .rx_byte(rx4), .spi_clk(sclk4), .mosi(mosi4), .miso(miso4), .cs_n(cs4)
    );

    spi_master #(.CLK_DIV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_byte(tx1), .busy(busy1), .done(done1),
        .rx_byte(rx1), .spi_clk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs1)
    );

    // Mode-1 responder: drives miso on rising spi_clk, samples mosi on falling spi_clk.
    always @(negedge cs4) respSh = respTx;
    always @(posedge sclk4) if (!cs4) begin
        respMiso = respSh[7];
        respSh   = {respSh[6:0], 1'b0};
    end
    always @(negedge sclk4) if (!cs4) respRx = {respRx[6:0], mosi4};

    int         rise4 = 0, doneCnt4 = 0, csLow4 = 0, csHighRun4 = 0, lastHighRun4 = 0;
    logic [7:0] mosiBits4 = 8'h00;
    time        doneT4[$];
    logic [7:0] doneRx4[$];
    time        csFallT4[$];
    logic       prevSclk4 = 1'b0, prevCs4 = 1'b1;

    always @(negedge clk) begin
        if (sclk4 && !prevSclk4) begin
            rise4++;
            mosiBits4 = {mosiBits4[6:0], mosi4};
        end
        prevSclk4 = sclk4;
        if (done4) begin
            doneCnt4++;
            doneT4.push_back($time - 5);
            doneRx4.push_back(rx4);
        end
        if (!cs4) begin
            csLow4++;
            if (prevCs4) csFallT4.push_back($time - 5);
            if (csHighRun4 > 0) lastHighRun4 = csHighRun4;
            csHighRun4 = 0;
        end else begin
            csHighRun4++;
        end
        prevCs4 = cs4;
    end

    int         rise1 = 0, doneCnt1 = 0;
    logic [7:0] mosiBits1 = 8'h00;
    time        doneT1[$];
    logic [7:0] doneRx1[$];
    logic       prevSclk1 = 1'b0;

    always @(negedge clk) begin
        if (sclk1 && !prevSclk1) begin
            rise1++;
            mosiBits1 = {mosiBits1[6:0], mosi1};
        end
        prevSclk1 = sclk1;
        if (done1) begin
            doneCnt1++;
            doneT1.push_back($time - 5);
            doneRx1.push_back(rx1);
        end
    end

    time t0;

    task automatic clearMon4();
        rise4 = 0; doneCnt4 = 0; csLow4 = 0; csHighRun4 = 0; lastHighRun4 = 0;
        doneT4.delete(); doneRx4.delete(); csFallT4.delete();
    endtask

    task automatic startXfer4(input logic [7:0] b);
        @(negedge clk);
        start4 = 1'b1;
        tx4    = b;
        @(posedge clk);
        t0 = $time;
        clearMon4();
        @(negedge clk);
        start4 = 1'b0;
        tx4    = 8'($urandom);
    endtask

    task automatic waitDone4(input int want, input int budget, output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (doneCnt4 >= want) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start4 = 1'b1;
        start1 = 1'b1;
        tx4    = 8'($urandom);
        tx1    = 8'($urandom);
        repeat (10) @(negedge clk);
        nTests++; if (sclk4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_spi_clk: got %b expected 0", sclk4); end
        nTests++; if (mosi4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi4); end
        nTests++; if (cs4 !== 1'b1) begin nFail++; $display("[TB] FAIL reset_cs_n: got %b expected 1", cs4); end
        nTests++; if (busy4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy4); end
        nTests++; if (done4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done: got %b expected 0", done4); end
        nTests++; if (rx4 !== 8'h00) begin nFail++; $display("[TB] FAIL reset_rx_byte: got %h expected 00", rx4); end
        nTests++; if (rise4 + rise1 !== 0) begin nFail++; $display("[TB] FAIL reset_no_toggle: got %0d rising edges expected 0", rise4 + rise1); end
        nTests++; if (cs1 !== 1'b1 || busy1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_div1_idle: got cs_n=%b busy=%b expected 1 0", cs1, busy1); end
        start4 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] b;
        bit         to;
        int         lat;
        loop4 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'hA5 : 8'($urandom);
            startXfer4(b);
            waitDone4(1, 200, to);
            repeat (10) @(negedge clk);
            lat = (doneT4.size() > 0) ? int'((doneT4[0] - t0) / 10) : -1;
            nTests++; if (to) begin nFail++; $display("[TB] FAIL loop_timeout: got no done expected done for %h", b); end
            nTests++; if (mosiBits4 !== b) begin nFail++; $display("[TB] FAIL loop_mosi_bits: got %h expected %h", mosiBits4, b); end
            nTests++; if (rise4 !== 8) begin nFail++; $display("[TB] FAIL loop_rise_count: got %0d expected 8", rise4); end
            nTests++; if (rx4 !== b) begin nFail++; $display("[TB] FAIL loop_rx_byte: got %h expected %h", rx4, b); end
            nTests++; if (lat !== 17 * 4 + 1) begin nFail++; $display("[TB] FAIL loop_latency: got %0d expected %0d", lat, 17 * 4 + 1); end
            nTests++; if (doneCnt4 !== 1) begin nFail++; $display("[TB] FAIL loop_done_pulses: got %0d expected 1", doneCnt4); end
            nTests++; if (csLow4 !== 17 * 4 + 1) begin nFail++; $display("[TB] FAIL loop_cs_low_cycles: got %0d expected %0d", csLow4, 17 * 4 + 1); end
        end
    endtask

    task automatic test_responder();
        bit to;
        loop4  = 1'b0;
        respTx = 8'h3C;
        respRx = 8'h00;
        startXfer4(8'hC3);
        waitDone4(1, 200, to);
        repeat (5) @(negedge clk);
        nTests++; if (to) begin nFail++; $display("[TB] FAIL resp_timeout: got no done expected done"); end
        nTests++; if (respRx !== 8'hC3) begin nFail++; $display("[TB] FAIL resp_captured: got %h expected c3", respRx); end
        nTests++; if (rx4 !== 8'h3C) begin nFail++; $display("[TB] FAIL resp_rx_byte: got %h expected 3c", rx4); end
        nTests++; if (csFallT4.size() !== 1 || csFallT4[0] !== t0) begin nFail++; $display("[TB] FAIL resp_cs_fall: got %0d falls expected 1 at E0", csFallT4.size()); end
        nTests++; if (csLow4 !== 69) begin nFail++; $display("[TB] FAIL resp_cs_low_cycles: got %0d expected 69", csLow4); end
        loop4 = 1'b1;
    endtask

    task automatic test_ignore_start();
        bit to;
        int lat;
        startXfer4(8'h12);
        repeat (2) @(negedge clk);
        start4 = 1'b1;
        tx4    = 8'hFF;
        @(negedge clk);
        start4 = 1'b0;
        waitDone4(1, 200, to);
        repeat (80) @(negedge clk);
        lat = (doneT4.size() > 0) ? int'((doneT4[0] - t0) / 10) : -1;
        nTests++; if (to) begin nFail++; $display("[TB] FAIL ign_timeout: got no done expected done"); end
        nTests++; if (rise4 !== 8) begin nFail++; $display("[TB] FAIL ign_rise_count: got %0d expected 8", rise4); end
        nTests++; if (doneCnt4 !== 1) begin nFail++; $display("[TB] FAIL ign_done_pulses: got %0d expected 1", doneCnt4); end
        nTests++; if (rx4 !== 8'h12) begin nFail++; $display("[TB] FAIL ign_rx_byte: got %h expected 12", rx4); end
        nTests++; if (lat !== 69) begin nFail++; $display("[TB] FAIL ign_latency: got %0d expected 69", lat); end
    endtask

    task automatic test_back_to_back();
        bit         to;
        bit         seen;
        logic [7:0] r0, r1;
        int         lat2;
        time        gap;
        @(negedge clk);
        start4 = 1'b1;
        tx4    = 8'h81;
        @(posedge clk);
        t0 = $time;
        clearMon4();
        @(negedge clk);
        tx4  = 8'h7E;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done4) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        waitDone4(2, 200, to);
        repeat (80) @(negedge clk);
        r0   = (doneRx4.size() > 0) ? doneRx4[0] : 8'hxx;
        r1   = (doneRx4.size() > 1) ? doneRx4[1] : 8'hxx;
        gap  = (csFallT4.size() > 1 && doneT4.size() > 0) ? (csFallT4[1] - doneT4[0]) / 10 : 0;
        lat2 = (csFallT4.size() > 1 && doneT4.size() > 1) ? int'((doneT4[1] - csFallT4[1]) / 10) : -1;
        nTests++; if (!seen || to) begin nFail++; $display("[TB] FAIL b2b_timeout: got seen=%b timeout=%b expected 1 0", seen, to); end
        nTests++; if (r0 !== 8'h81) begin nFail++; $display("[TB] FAIL b2b_first_rx: got %h expected 81", r0); end
        nTests++; if (r1 !== 8'h7E) begin nFail++; $display("[TB] FAIL b2b_second_rx: got %h expected 7e", r1); end
        nTests++; if (lastHighRun4 !== 1) begin nFail++; $display("[TB] FAIL b2b_cs_high_gap: got %0d cycles expected 1", lastHighRun4); end
        nTests++; if (gap !== 1) begin nFail++; $display("[TB] FAIL b2b_restart_delay: got %0d expected 1", gap); end
        nTests++; if (doneCnt4 !== 2 || rise4 !== 16) begin nFail++; $display("[TB] FAIL b2b_counts: got done=%0d rises=%0d expected 2 16", doneCnt4, rise4); end
        nTests++; if (lat2 !== 69) begin nFail++; $display("[TB] FAIL b2b_second_latency: got %0d expected 69", lat2); end
    endtask

    task automatic test_reset_abort();
        bit         reached;
        bit         to;
        logic [7:0] b;
        int         lat;
        startXfer4(8'($urandom));
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rise4 >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        nTests++; if (!reached) begin nFail++; $display("[TB] FAIL abort_third_rise: got %0d rises expected 3", rise4); end
        nTests++; if (sclk4 !== 1'b0 || mosi4 !== 1'b0) begin nFail++; $display("[TB] FAIL abort_bus_idle: got spi_clk=%b mosi=%b expected 0 0", sclk4, mosi4); end
        nTests++; if (cs4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin nFail++; $display("[TB] FAIL abort_ctrl_idle: got cs_n=%b busy=%b done=%b expected 1 0 0", cs4, busy4, done4); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        nTests++; if (doneCnt4 !== 0) begin nFail++; $display("[TB] FAIL abort_no_done: got %0d expected 0", doneCnt4); end
        for (int n = 0; n < 3; n++) begin
            b = (n == 0) ? 8'h5A : 8'($urandom);
            @(negedge clk);
            start1 = 1'b1;
            tx1    = b;
            @(posedge clk);
            t0 = $time;
            rise1 = 0; doneCnt1 = 0; doneT1.delete(); doneRx1.delete();
            @(negedge clk);
            start1 = 1'b0;
            tx1    = ~b;
            to = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                if (doneCnt1 > 0) begin
                    to = 1'b0;
                    break;
                end
            end
            repeat (5) @(negedge clk);
            lat = (doneT1.size() > 0) ? int'((doneT1[0] - t0) / 10) : -1;
            nTests++; if (to) begin nFail++; $display("[TB] FAIL div1_timeout: got no done expected done for %h", b); end
            nTests++; if (rx1 !== b) begin nFail++; $display("[TB] FAIL div1_rx_byte: got %h expected %h", rx1, b); end
            nTests++; if (mosiBits1 !== b || rise1 !== 8) begin nFail++; $display("[TB] FAIL div1_mosi: got %h over %0d rises expected %h over 8", mosiBits1, rise1, b); end
            nTests++; if (lat !== 18 || doneCnt1 !== 1) begin nFail++; $display("[TB] FAIL div1_latency: got %0d (%0d pulses) expected 18 (1)", lat, doneCnt1); end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_responder();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
